// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: produces the w_en/bubble pairs for the four pipeline
// buffers and the PC write enable, handling load-use, taken-branch and memory-wait hazards.
module pipe_hazard_ctrl #(
  parameter int RA_W     = 4,
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_br_taken,
  input  logic            mem_req,
  output logic            pc_w_en,
  output logic            if_id_w_en,
  output logic            if_id_bubble,
  output logic            id_ex_w_en,
  output logic            id_ex_bubble,
  output logic            ex_mem_w_en,
  output logic            ex_mem_bubble,
  output logic            mem_wb_w_en,
  output logic            mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_INIT = (MEM_WAIT > 0) ? WCNT_W'(MEM_WAIT - 1) : '0;

  typedef enum logic {RUN, MWAIT} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
  logic                flush_evt;
  logic                load_use;

  assign load_use = ex_is_load &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    // NOTE: every output gets a default before any branch so no path infers a latch.
    pc_w_en       = 1'b1;
    if_id_w_en    = 1'b1;
    if_id_bubble  = 1'b0;
    id_ex_w_en    = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_w_en   = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_w_en   = 1'b1;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    flush_evt     = 1'b0;

    if (reset) begin
      pc_w_en       = 1'b0;
      if_id_w_en    = 1'b0;
      if_id_bubble  = 1'b1;
      id_ex_w_en    = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_w_en   = 1'b0;
      ex_mem_bubble = 1'b1;
      mem_wb_w_en   = 1'b0;
      mem_wb_bubble = 1'b1;
      state_d       = RUN;
      wcnt_d        = '0;
    end else if ((state_q == RUN && mem_req && MEM_WAIT > 0) ||
                 (state_q == MWAIT && wcnt_q != '0)) begin
      // Memory freeze: everything upstream of MEM holds, MEM/WB receives a NOP.
      pc_w_en       = 1'b0;
      if_id_w_en    = 1'b0;
      id_ex_w_en    = 1'b0;
      ex_mem_w_en   = 1'b0;
      mem_wb_bubble = 1'b1;
      if (state_q == RUN) begin
        state_d = MWAIT;
        wcnt_d  = WAIT_INIT;
      end else begin
        wcnt_d  = wcnt_q - WCNT_W'(1);
      end
    end else begin
      // Release cycle ignores mem_req: it is still the access that just finished.
      state_d = RUN;
      if (ex_br_taken) begin
        if_id_bubble = 1'b1;
        id_ex_bubble = 1'b1;
        flush_evt    = 1'b1;
      end else if (load_use) begin
        pc_w_en      = 1'b0;
        if_id_w_en   = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (!pc_w_en && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
